// File: rtl/int_issue_queue_pkg.sv
// Shared types and helpers for the integer issue queue.
package int_issue_queue_pkg;

  localparam int TAG_W = 6;
  localparam int SQN_W = 6;

  typedef enum logic [3:0] {
    INT_ADD  = 4'd0,
    INT_SUB  = 4'd1,
    INT_XOR  = 4'd2,
    INT_OR   = 4'd3,
    INT_AND  = 4'd4,
    INT_SLL  = 4'd5,
    INT_SRL  = 4'd6,
    INT_SRA  = 4'd7,
    INT_SLT  = 4'd8,
    INT_SLTU = 4'd9,
    INT_LUI  = 4'd10,
    INT_JAL  = 4'd11
  } OPCode_INT;

  typedef struct packed {
    logic                  valid;
    OPCode_INT             opcode;
    logic [2:0][31:0]      op;
    logic [1:0]            rdy;
    logic [1:0][TAG_W-1:0] tag;
    logic [TAG_W-1:0]      tagDst;
    logic [4:0]            nmDst;
    logic [SQN_W-1:0]      sqN;
  } IQEntry;

  // Modulo age compare: valid while fewer than half the sqN space is in flight.
  function automatic logic is_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
    logic [SQN_W-1:0] diff;
    diff = a - b;
    return diff[SQN_W-1];
  endfunction

endpackage

// File: rtl/int_issue_queue_if.sv
// Dispatch, wakeup, flush and issue bundle of the integer issue queue.
interface int_issue_queue_if #(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 2
);
  import int_issue_queue_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                         IN_valid;
  logic [2:0][31:0]             IN_operands;
  logic [1:0][TAG_W-1:0]        IN_srcTag;
  logic [1:0]                   IN_srcReady;
  OPCode_INT                    IN_opcode;
  logic [TAG_W-1:0]             IN_tagDst;
  logic [4:0]                   IN_nmDst;
  logic [SQN_W-1:0]             IN_sqN;
  logic                         OUT_full;
  logic [CNT_W-1:0]             OUT_count;
  logic [NUM_WB-1:0]            IN_wbValid;
  logic [NUM_WB-1:0][TAG_W-1:0] IN_wbTag;
  logic [NUM_WB-1:0][31:0]      IN_wbResult;
  logic                         IN_wbStall;
  logic                         IN_branchTaken;
  logic [SQN_W-1:0]             IN_branchSqN;
  logic                         OUT_valid;
  logic [2:0][31:0]             OUT_operands;
  OPCode_INT                    OUT_opcode;
  logic [TAG_W-1:0]             OUT_tagDst;
  logic [4:0]                   OUT_nmDst;
  logic [SQN_W-1:0]             OUT_sqN;

  modport master (
    output IN_valid, IN_operands, IN_srcTag, IN_srcReady, IN_opcode, IN_tagDst, IN_nmDst, IN_sqN,
    output IN_wbValid, IN_wbTag, IN_wbResult, IN_wbStall, IN_branchTaken, IN_branchSqN,
    input  OUT_full, OUT_count, OUT_valid, OUT_operands, OUT_opcode, OUT_tagDst, OUT_nmDst, OUT_sqN
  );

  modport slave (
    input  IN_valid, IN_operands, IN_srcTag, IN_srcReady, IN_opcode, IN_tagDst, IN_nmDst, IN_sqN,
    input  IN_wbValid, IN_wbTag, IN_wbResult, IN_wbStall, IN_branchTaken, IN_branchSqN,
    output OUT_full, OUT_count, OUT_valid, OUT_operands, OUT_opcode, OUT_tagDst, OUT_nmDst, OUT_sqN
  );

endinterface

// File: rtl/int_issue_queue_age_select.sv
// Combinational oldest-ready picker: one-hot grant to the oldest ready entry by sqN.
module iq_age_select
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][SQN_W-1:0] sqn,
  output logic [DEPTH-1:0]            grant,
  output logic                        found
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] best;

  // sqNs in the queue are unique, so a linear scan yields a strict oldest.
  always_comb begin
    grant = '0;
    found = 1'b0;
    best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!found || is_older(sqn[i], sqn[best]))) begin
        found = 1'b1;
        best  = IDX_W'(i);
      end
    end
    if (found) grant[best] = 1'b1;
  end

endmodule

// File: rtl/int_issue_queue.sv
// Integer ALU issue queue: enqueue, operand wakeup, branch flush and oldest-ready issue.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_WB = 2
) (
  input logic           clk,
  input logic           rst,
  int_issue_queue_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  IQEntry [DEPTH-1:0]            entries;
  IQEntry [DEPTH-1:0]            entries_nxt;
  IQEntry                        new_ent;
  logic   [DEPTH-1:0]            ready;
  logic   [DEPTH-1:0][SQN_W-1:0] sqn;
  logic   [DEPTH-1:0]            grant;
  logic   [DEPTH-1:0]            free_oh;
  logic                          found;
  logic                          issue;
  logic                          enq;
  logic   [CNT_W-1:0]            count_nxt;
  logic   [2:0][31:0]            sel_op;
  OPCode_INT                     sel_opcode;
  logic   [TAG_W-1:0]            sel_tagDst;
  logic   [4:0]                  sel_nmDst;
  logic   [SQN_W-1:0]            sel_sqN;

  function automatic IQEntry wake(input IQEntry e,
                                  input logic [NUM_WB-1:0] v,
                                  input logic [NUM_WB-1:0][TAG_W-1:0] t,
                                  input logic [NUM_WB-1:0][31:0] r);
    IQEntry w;
    w = e;
    // Descending scan so the lowest matching port is applied last and wins.
    for (int s = 0; s < 2; s++) begin
      if (e.valid && !e.rdy[s]) begin
        for (int k = NUM_WB - 1; k >= 0; k--) begin
          if (v[k] && t[k] == e.tag[s]) begin
            w.op[s]  = r[k];
            w.rdy[s] = 1'b1;
          end
        end
      end
    end
    return w;
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = entries[i].valid && (&entries[i].rdy);
      sqn[i]   = entries[i].sqN;
    end
  end

  iq_age_select #(.DEPTH(DEPTH)) u_age_select (
    .ready (ready),
    .sqn   (sqn),
    .grant (grant),
    .found (found)
  );

  always_comb begin
    sel_op     = '0;
    sel_opcode = INT_ADD;
    sel_tagDst = '0;
    sel_nmDst  = '0;
    sel_sqN    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_op     = entries[i].op;
        sel_opcode = entries[i].opcode;
        sel_tagDst = entries[i].tagDst;
        sel_nmDst  = entries[i].nmDst;
        sel_sqN    = entries[i].sqN;
      end
    end

    issue = found && !bus.IN_wbStall &&
            !(bus.IN_branchTaken && is_older(bus.IN_branchSqN, sel_sqN));
    enq   = bus.IN_valid && !bus.OUT_full &&
            !(bus.IN_branchTaken && is_older(bus.IN_branchSqN, bus.IN_sqN));

    // Free slots come from start-of-cycle state, so issued slots are reused next cycle.
    free_oh = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!entries[i].valid && free_oh == '0) free_oh[i] = 1'b1;
    end

    new_ent.valid  = 1'b1;
    new_ent.opcode = bus.IN_opcode;
    new_ent.op     = bus.IN_operands;
    new_ent.rdy    = bus.IN_srcReady;
    new_ent.tag    = bus.IN_srcTag;
    new_ent.tagDst = bus.IN_tagDst;
    new_ent.nmDst  = bus.IN_nmDst;
    new_ent.sqN    = bus.IN_sqN;
    new_ent        = wake(new_ent, bus.IN_wbValid, bus.IN_wbTag, bus.IN_wbResult);

    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries_nxt[i] = wake(entries[i], bus.IN_wbValid, bus.IN_wbTag, bus.IN_wbResult);
      if (bus.IN_branchTaken && is_older(bus.IN_branchSqN, entries[i].sqN))
        entries_nxt[i].valid = 1'b0;
      if (issue && grant[i])
        entries_nxt[i].valid = 1'b0;
      if (enq && free_oh[i])
        entries_nxt[i] = new_ent;
      count_nxt = count_nxt + CNT_W'(entries_nxt[i].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries          <= '0;
      bus.OUT_count    <= '0;
      bus.OUT_full     <= 1'b0;
      bus.OUT_valid    <= 1'b0;
      bus.OUT_operands <= '0;
      bus.OUT_opcode   <= INT_ADD;
      bus.OUT_tagDst   <= '0;
      bus.OUT_nmDst    <= '0;
      bus.OUT_sqN      <= '0;
    end else begin
      entries       <= entries_nxt;
      bus.OUT_count <= count_nxt;
      bus.OUT_full  <= (count_nxt == CNT_W'(DEPTH));
      bus.OUT_valid <= issue;
      if (issue) begin
        bus.OUT_operands <= sel_op;
        bus.OUT_opcode   <= sel_opcode;
        bus.OUT_tagDst   <= sel_tagDst;
        bus.OUT_nmDst    <= sel_nmDst;
        bus.OUT_sqN      <= sel_sqN;
      end
    end
  end

endmodule

// File: doc/int_issue_queue.md
# int_issue_queue

Out-of-order issue queue for the integer ALU. It buffers up to `DEPTH` renamed integer ops and captures operand values from result-bus broadcasts. Each cycle it selects the oldest op whose sources are both ready and drives it into the ALU input register. It sits between rename/dispatch and the ALU, honours the ALU writeback stall, and squashes wrong-path ops on a taken-branch flush.

## Interface
Parameters:
- `DEPTH`, 8: number of entries; power of two, 4..16.
- `NUM_WB`, 2: number of result-bus wakeup ports.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `IN_valid` in 1: enqueue request.
- `IN_operands[2:0]` in 3×32: src0, src1, imm/target; src values are valid only if the matching ready bit is set.
- `IN_srcTag[1:0]` in 2×6: physical tags of src0/src1.
- `IN_srcReady[1:0]` in 2: source value already present.
- `IN_opcode` in `OPCode_INT`: ALU opcode.
- `IN_tagDst` in 6, `IN_nmDst` in 5, `IN_sqN` in 6: destination tag, architectural reg, sequence number.
- `OUT_full` out 1: queue full; enqueue is ignored while high.
- `OUT_count` out log2(DEPTH)+1: occupied entries.
- `IN_wbValid[NUM_WB-1:0]` in 1 each, `IN_wbTag[]` in 6, `IN_wbResult[]` in 32: wakeup broadcasts.
- `IN_wbStall` in 1: ALU cannot accept an op this cycle.
- `IN_branchTaken` in 1, `IN_branchSqN` in 6: flush ops younger than `IN_branchSqN`.
- `OUT_valid` out 1, `OUT_operands[2:0]` out 3×32, `OUT_opcode`, `OUT_tagDst` 6, `OUT_nmDst` 5, `OUT_sqN` 6: registered issue to ALU.

## Operation
- Entry fields: `valid`, `opcode`, `op[2:0]`, `rdy[1:0]`, `tag[1:0]`, `tagDst`, `nmDst`, `sqN`.
- **Age:** a is older than b iff `$signed(a - b) < 0` (6-bit modulo). At most 32 ops are in flight, so wrap is safe.
- **Enqueue:** if `IN_valid && !OUT_full`, write the lowest-index free slot. A source whose tag matches any valid wb port in the same cycle is written ready with the broadcast value.
- **Wakeup:** for every valid entry, each non-ready source whose tag equals a valid `IN_wbTag[k]` latches `IN_wbResult[k]` and sets `rdy`. If two ports hit the same tag, the lower port index wins.
- **Select:** candidates are valid entries with `rdy == 2'b11`, using state at the start of the cycle; same-cycle wakeup is not bypassed into select. Pick the oldest by sqN.
- **Issue:** if a candidate exists and `!IN_wbStall`, load the OUT_ registers, set `OUT_valid`, and clear the entry. Otherwise `OUT_valid <= 0` and no entry changes.
- **Flush:** if `IN_branchTaken`:
  - Invalidate every entry with sqN younger than `IN_branchSqN`.
  - Drop a same-cycle enqueue whose `IN_sqN` is younger.
  - Suppress issue of a younger selected op.
  - Clear `OUT_valid` if the op being loaded is younger.
  - Entries older than or equal to `IN_branchSqN` are untouched.
- **Priority in one cycle:** flush, then issue, then enqueue. A slot freed by issue is not reusable until the next cycle. `OUT_full` and `OUT_count` are registered and reflect end-of-cycle occupancy.

## Timing
- Reset values: all entries invalid; `OUT_valid` = 0; `OUT_count` = 0; `OUT_full` = 0; all other OUT_ registers 0.
- `rst` overrides all other inputs in the same edge, including mid-flush and mid-issue.
- Enqueue of a fully ready op at edge t: selectable in cycle t+1, `OUT_valid` high after edge t+1. Minimum queue latency is 1 cycle.
- Wakeup at edge t makes the entry selectable in cycle t+1.
- Throughput: one issue per cycle and one enqueue per cycle.
- `OUT_full` rises the edge count reaches DEPTH. It falls the edge after an issue or flush reduces the count.

## Structure
- The shared package holds:
  - `OPCode_INT`.
  - A `IQEntry` struct typedef.
  - `TAG_W` = 6, `SQN_W` = 6.
  - The age-compare function.
- One sub-module, `iq_age_select`: combinational oldest-ready selector over `DEPTH` entries, outputting a one-hot grant and a found flag.
- Enqueue, wakeup, flush and issue logic live in `int_issue_queue`.

## Test plan
- **Back-to-back ready ops:** enqueue ADD (op0=5, op1=7, both ready) then XOR. ADD issues the edge after enqueue (`OUT_operands[0]`=5, `OUT_operands[1]`=7); XOR issues one cycle later; `OUT_count` returns to 0.
- **Wakeup:** enqueue SUB with src1 tag 12 not ready. Later broadcast tag 12, result 0x100, on port 1. SUB issues the following cycle with `OUT_operands[1]`=0x100. Also cover enqueue in the same cycle as the broadcast.
- **Age select with wrap:** entries with sqN 62, 63, 1, all ready. Issue order must be 62, 63, 1 regardless of slot index.
- **Stall:** hold `IN_wbStall` for 3 cycles with 2 ready ops. `OUT_valid` = 0 and count = 2 throughout; the older op issues the cycle after the stall drops.
- **Full and flush:** fill DEPTH=8 (sqN 10..17); `OUT_full` = 1 and a 9th enqueue is ignored. Then pulse branchTaken with branchSqN=13 alongside a younger enqueue. Count becomes 4 (sqN 10..13), `OUT_full` = 0, the younger enqueue is dropped, and no sqN > 13 ever issues.
- **Reset:** assert `rst` with a partly full queue and `OUT_valid` = 1. Next cycle all outputs are at reset values and subsequent enqueues behave normally.
